sparrow_dmem_resp: RTL and testbench

SPARROW_DMEM_RESP -- requirements
Module: sparrow_dmem_resp

---
 rtl/sparrow_pkg.sv | 29 ++
 rtl/sparrow_sync_fifo.sv | 73 +++++++
 rtl/sparrow_dmem_resp.sv | 162 ++++++++++++++++
 tb/tb_sparrow_dmem_resp.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sparrow_pkg.sv
// Shared definitions for the sparrow data-memory responder: access-size
// encoding, MMIO register addresses and the size decode helper.
package sparrow_pkg;

    // Access size as carried on i_dmem_byte_en (2'b11 folds into WORD).
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } acc_size_e;

    // MMIO register map (word-only accesses).
    localparam logic [31:0] MMIO_CYCLE     = 32'h8000_0000;
    localparam logic [31:0] MMIO_ERRCNT    = 32'h8000_0004;
    localparam logic [31:0] MMIO_CONS_TX   = 32'h8000_0008;
    localparam logic [31:0] MMIO_CONS_STAT = 32'h8000_000C;

    // CONS_STAT value when the console path is compiled out: empty, not full.
    localparam logic [31:0] CONS_STAT_IDLE = 32'h0000_0002;

    function automatic acc_size_e decode_size(input logic [1:0] byte_en);
        case (byte_en)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/sparrow_sync_fifo.sv
// Synchronous FIFO used as the console transmit queue. A push while full is
// accepted only if a pop happens in the same cycle; otherwise it is dropped
// and the caller is expected to account for the loss.
module sparrow_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem[rd_ptr_q];
    assign o_count = count_q;

    // Next-state for pointers and occupancy.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        do_pop   = i_pop && !o_empty;
        do_push  = i_push && (!o_full || do_pop);
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer/occupancy registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (i_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge i_clk) begin
        // NOTE: storage is not reset; the occupancy count alone defines which entries are valid.
        if (do_push && !i_reset) begin
            mem[wr_ptr_q] <= i_push_data;
        end
    end

endmodule

// File: rtl/sparrow_dmem_resp.sv
// Zero-latency data-memory responder for the sparrow core: byte/half/word RAM
// plus MMIO registers CYCLE, ERRCNT, CONS_TX and CONS_STAT.
// Optional console FIFO path is compiled in with SPARROW_DMEM_CONSOLE_EN.
module sparrow_dmem_resp
    import sparrow_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int CONS_DEPTH  = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_dmem_req,
    input  logic [31:0] i_dmem_addr,
    input  logic [1:0]  i_dmem_byte_en,
    input  logic        i_dmem_wr_en,
    input  logic [31:0] i_dmem_wr_data,
    output logic [31:0] o_dmem_rd_data,
    output logic        o_cons_valid,
    output logic [7:0]  o_cons_data,
    input  logic        i_cons_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(CONS_DEPTH + 1);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   errcnt_q, errcnt_d;

    acc_size_e     size;
    logic [AW-1:0] word_idx;
    logic          is_mmio, misaligned, ram_range_err, mmio_err, err_access;
    logic          hit_cycle, hit_errcnt, hit_cons_tx, hit_cons_stat;
    logic          wr_access, ram_we, errcnt_clr, cons_push, cons_drop;
    logic [3:0]    lane_we;
    logic [31:0]   lane_wdata, ram_word, cons_stat, rd_data;

    assign word_idx = i_dmem_addr[AW+1:2];
    assign ram_word = mem[word_idx];

    // Address/size decode, error classification, write lanes and read mux.
    always_comb begin
        size          = decode_size(i_dmem_byte_en);
        is_mmio       = i_dmem_addr[31];
        misaligned    = ((size == SZ_HALF) && i_dmem_addr[0]) ||
                        ((size == SZ_WORD) && (i_dmem_addr[1:0] != 2'b00));
        ram_range_err = !is_mmio && ((i_dmem_addr[30:0] >> (AW + 2)) != 31'd0);
        hit_cycle     = (size == SZ_WORD) && (i_dmem_addr == MMIO_CYCLE);
        hit_errcnt    = (size == SZ_WORD) && (i_dmem_addr == MMIO_ERRCNT);
        hit_cons_tx   = (size == SZ_WORD) && (i_dmem_addr == MMIO_CONS_TX);
        hit_cons_stat = (size == SZ_WORD) && (i_dmem_addr == MMIO_CONS_STAT);
        mmio_err      = is_mmio && !(hit_cycle || hit_errcnt || hit_cons_tx || hit_cons_stat);
        err_access    = i_dmem_req && (misaligned || ram_range_err || mmio_err);

        wr_access  = i_dmem_req && i_dmem_wr_en && !err_access;
        ram_we     = wr_access && !is_mmio && !i_reset;
        errcnt_clr = wr_access && hit_errcnt;
        cons_push  = wr_access && hit_cons_tx;

        lane_we    = 4'b1111;
        lane_wdata = i_dmem_wr_data;
        unique case (size)
            SZ_BYTE: begin
                lane_we    = 4'b0001 << i_dmem_addr[1:0];
                lane_wdata = {4{i_dmem_wr_data[7:0]}};
            end
            SZ_HALF: begin
                lane_we    = i_dmem_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{i_dmem_wr_data[15:0]}};
            end
            default: begin
                lane_we    = 4'b1111;
                lane_wdata = i_dmem_wr_data;
            end
        endcase

        rd_data = '0;
        if (i_dmem_req && !i_dmem_wr_en && !err_access) begin
            if (!is_mmio) begin
                unique case (size)
                    SZ_BYTE: rd_data = {24'h0, ram_word[{i_dmem_addr[1:0], 3'b000} +: 8]};
                    SZ_HALF: rd_data = {16'h0, i_dmem_addr[1] ? ram_word[31:16] : ram_word[15:0]};
                    default: rd_data = ram_word;
                endcase
            end else if (hit_cycle) begin
                rd_data = cycle_q;
            end else if (hit_errcnt) begin
                rd_data = errcnt_q;
            end else if (hit_cons_stat) begin
                rd_data = cons_stat;
            end
        end

        cycle_d  = cycle_q + 32'd1;
        errcnt_d = errcnt_q;
        if (errcnt_clr) begin
            errcnt_d = '0;
        end else if ((err_access || cons_drop) && (errcnt_q != '1)) begin
            errcnt_d = errcnt_q + 32'd1;
        end
    end

    assign o_dmem_rd_data = rd_data;

    // CYCLE and ERRCNT registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cycle_q  <= '0;
            errcnt_q <= '0;
        end else begin
            cycle_q  <= cycle_d;
            errcnt_q <= errcnt_d;
        end
    end

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_we[b]) begin
                    mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef SPARROW_DMEM_CONSOLE_EN
    logic          fifo_full, fifo_empty, cons_pop;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;

    assign cons_pop = !fifo_empty && i_cons_ready;

    sparrow_sync_fifo #(
        .WIDTH (8),
        .DEPTH (CONS_DEPTH)
    ) u_cons_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (cons_push),
        .i_push_data (i_dmem_wr_data[7:0]),
        .i_pop       (cons_pop),
        .o_head      (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count)
    );

    assign cons_drop    = cons_push && fifo_full && !cons_pop;
    assign o_cons_valid = !fifo_empty;
    assign o_cons_data  = fifo_empty ? 8'h00 : fifo_head;
    assign cons_stat    = {16'h0, 8'(fifo_count), 6'b0, fifo_empty, fifo_full};
`else
    logic unused_cons;
    assign unused_cons  = cons_push ^ i_cons_ready;
    assign cons_drop    = 1'b0;
    assign o_cons_valid = 1'b0;
    assign o_cons_data  = 8'h00;
    assign cons_stat    = CONS_STAT_IDLE;
`endif

endmodule

// File: tb/tb_sparrow_dmem_resp.sv
// Directed self-checking bench for sparrow_dmem_resp, plus a standalone
// exercise of sparrow_sync_fifo. Console checks follow SPARROW_DMEM_CONSOLE_EN.
module tb_sparrow_dmem_resp;
    import sparrow_pkg::*;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic [1:0]  be;
    logic        wr_en;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        cons_valid;
    logic [7:0]  cons_data;
    logic        cons_ready;

    logic        f_reset, f_push, f_pop;
    logic [7:0]  f_data, f_head;
    logic        f_full, f_empty;
    logic [2:0]  f_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [31:0] obs;

    sparrow_dmem_resp #(
        .DEPTH_WORDS (1024),
        .CONS_DEPTH  (4)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_dmem_req     (req),
        .i_dmem_addr    (addr),
        .i_dmem_byte_en (be),
        .i_dmem_wr_en   (wr_en),
        .i_dmem_wr_data (wdata),
        .o_dmem_rd_data (rd_data),
        .o_cons_valid   (cons_valid),
        .o_cons_data    (cons_data),
        .i_cons_ready   (cons_ready)
    );

    sparrow_sync_fifo #(
        .WIDTH (8),
        .DEPTH (4)
    ) u_fifo (
        .i_clk       (clk),
        .i_reset     (f_reset),
        .i_push      (f_push),
        .i_push_data (f_data),
        .i_pop       (f_pop),
        .o_head      (f_head),
        .o_full      (f_full),
        .o_empty     (f_empty),
        .o_count     (f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // All access tasks start and end 1 time unit after a rising edge.
    task automatic rd(input logic [31:0] a, input logic [1:0] size, output logic [31:0] data);
        req = 1'b1; wr_en = 1'b0; addr = a; be = size; wdata = '0;
        @(negedge clk);
        data = rd_data;
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d,
                      output logic [31:0] data);
        req = 1'b1; wr_en = 1'b1; addr = a; be = size; wdata = d;
        @(negedge clk);
        data = rd_data;
        @(posedge clk); #1;
        req = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; be = 2'b10; wr_en = 1'b0; wdata = '0;
        cons_ready = 1'b0;
        f_reset = 1'b1; f_push = 1'b0; f_pop = 1'b0; f_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; f_reset = 1'b0;

        // Reset state and cycle counter.
        repeat (10) @(posedge clk);
        #1;
        rd(MMIO_CYCLE, 2'b10, obs);         check("cycle_after_10", obs, 32'd10);
        addr = MMIO_CYCLE; be = 2'b10; req = 1'b0;
        @(negedge clk);
        check("rd_idle_zero", rd_data, 32'h0);
        check("reset_cons_valid", {31'h0, cons_valid}, 32'h0);
        check("reset_cons_data", {24'h0, cons_data}, 32'h0);
        @(posedge clk); #1;
        rd(MMIO_ERRCNT, 2'b10, obs);        check("reset_errcnt", obs, 32'h0);

        // Word write, then narrow reads.
        wr(32'h40, 2'b10, 32'hDEAD_BEEF, obs);
        rd(32'h41, 2'b00, obs);             check("byte_rd_41", obs, 32'h0000_00BE);
        rd(32'h42, 2'b01, obs);             check("half_rd_42", obs, 32'h0000_DEAD);
        rd(32'h40, 2'b00, obs);             check("byte_rd_40", obs, 32'h0000_00EF);
        rd(32'h43, 2'b00, obs);             check("byte_rd_43", obs, 32'h0000_00DE);
        rd(32'h40, 2'b11, obs);             check("word11_rd_40", obs, 32'hDEAD_BEEF);

        // Narrow writes touch only their lanes.
        wr(32'h43, 2'b00, 32'hFFFF_FF55, obs);
        rd(32'h40, 2'b10, obs);             check("byte_wr_43", obs, 32'h55AD_BEEF);
        wr(32'h40, 2'b01, 32'hABCD_1234, obs);
        rd(32'h40, 2'b10, obs);             check("half_wr_40", obs, 32'h55AD_1234);

        // Error accesses.
        wr(32'h42, 2'b10, 32'h1111_1111, obs); check("misal_wr_rd", obs, 32'h0);
        rd(32'h40, 2'b10, obs);             check("misal_wr_ram", obs, 32'h55AD_1234);
        rd(MMIO_ERRCNT, 2'b10, obs);        check("errcnt_1", obs, 32'd1);
        wr(MMIO_ERRCNT, 2'b10, 32'h0, obs);
        rd(MMIO_ERRCNT, 2'b10, obs);        check("errcnt_clr", obs, 32'd0);
        rd(32'h41, 2'b01, obs);             check("misal_half_rd", obs, 32'h0);
        rd(32'h1000, 2'b10, obs);           check("range_rd", obs, 32'h0);
        rd(MMIO_CYCLE, 2'b00, obs);         check("mmio_byte_rd", obs, 32'h0);
        rd(32'h8000_0010, 2'b10, obs);      check("mmio_bad_rd", obs, 32'h0);
        wr(32'h1040, 2'b10, 32'hCAFE_F00D, obs);
        rd(32'h40, 2'b10, obs);             check("range_wr_alias", obs, 32'h55AD_1234);
        rd(MMIO_ERRCNT, 2'b10, obs);        check("errcnt_5", obs, 32'd5);
        wr(MMIO_ERRCNT, 2'b10, 32'hFFFF_FFFF, obs);
        rd(MMIO_ERRCNT, 2'b10, obs);        check("errcnt_clr2", obs, 32'd0);

`ifdef SPARROW_DMEM_CONSOLE_EN
        // Overfill the console FIFO while the sink stalls.
        for (int i = 0; i < 5; i++) begin
            wr(MMIO_CONS_TX, 2'b10, 32'h41 + 32'(i), obs);
        end
        @(negedge clk);
        check("cons_head_stall", {24'h0, cons_data}, 32'h41);
        @(posedge clk); #1;
        rd(MMIO_CONS_STAT, 2'b10, obs);     check("cons_stat_full", obs, 32'h0000_0401);
        rd(MMIO_ERRCNT, 2'b10, obs);        check("cons_drop_err", obs, 32'd1);
        check("cons_head_stable", {24'h0, cons_data}, 32'h41);

        // Drain in order.
        cons_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain_valid", {31'h0, cons_valid}, 32'h1);
            check("drain_data", {24'h0, cons_data}, 32'h41 + 32'(i));
        end
        @(posedge clk); #1;
        cons_ready = 1'b0;
        check("drain_empty", {31'h0, cons_valid}, 32'h0);
        rd(MMIO_CONS_STAT, 2'b10, obs);     check("cons_stat_empty", obs, 32'h0000_0002);

        // Push and pop together while full: nothing dropped.
        for (int i = 0; i < 4; i++) begin
            wr(MMIO_CONS_TX, 2'b10, 32'h61 + 32'(i), obs);
        end
        cons_ready = 1'b1;
        wr(MMIO_CONS_TX, 2'b10, 32'h65, obs);
        cons_ready = 1'b0;
        rd(MMIO_CONS_STAT, 2'b10, obs);     check("pushpop_stat", obs, 32'h0000_0401);
        rd(MMIO_ERRCNT, 2'b10, obs);        check("pushpop_errcnt", obs, 32'd1);
        check("pushpop_head", {24'h0, cons_data}, 32'h62);

        // Leave two bytes queued before reset.
        cons_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cons_ready = 1'b0;
        check("two_left_head", {24'h0, cons_data}, 32'h64);
        rd(MMIO_CONS_STAT, 2'b10, obs);     check("two_left_stat", obs, 32'h0000_0200);
`else
        wr(MMIO_CONS_TX, 2'b10, 32'h41, obs);
        rd(MMIO_ERRCNT, 2'b10, obs);        check("nocons_errcnt", obs, 32'd0);
        rd(MMIO_CONS_STAT, 2'b10, obs);     check("nocons_stat", obs, 32'h0000_0002);
        check("nocons_valid", {31'h0, cons_valid}, 32'h0);
`endif

        // Reset mid-transfer with a write attempted during reset.
        rst = 1'b1;
        req = 1'b1; wr_en = 1'b1; addr = 32'h40; be = 2'b10; wdata = 32'h0BAD_BAD0;
        @(posedge clk); #1;
        check("rst_cons_valid", {31'h0, cons_valid}, 32'h0);
        check("rst_cons_data", {24'h0, cons_data}, 32'h0);
        rst = 1'b0; req = 1'b0; wr_en = 1'b0;
        rd(MMIO_CYCLE, 2'b10, obs);         check("rst_cycle", obs, 32'd0);
        rd(MMIO_CONS_STAT, 2'b10, obs);     check("rst_cons_stat", obs, 32'h0000_0002);
        rd(MMIO_ERRCNT, 2'b10, obs);        check("rst_errcnt", obs, 32'd0);
        rd(32'h40, 2'b10, obs);             check("rst_ram_kept", obs, 32'h55AD_1234);

        // Standalone FIFO: fill, push while full, push+pop while full, drain.
        for (int i = 0; i < 4; i++) begin
            f_push = 1'b1; f_data = 8'hA1 + 8'(i);
            @(posedge clk); #1;
        end
        f_push = 1'b0;
        check("fifo_full", {31'h0, f_full}, 32'h1);
        check("fifo_count4", {29'h0, f_count}, 32'd4);
        f_push = 1'b1; f_data = 8'hEE;
        @(posedge clk); #1;
        f_push = 1'b0;
        check("fifo_drop_count", {29'h0, f_count}, 32'd4);
        check("fifo_drop_head", {24'h0, f_head}, 32'hA1);
        f_push = 1'b1; f_pop = 1'b1; f_data = 8'hA5;
        @(posedge clk); #1;
        f_push = 1'b0; f_pop = 1'b0;
        check("fifo_pp_count", {29'h0, f_count}, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("fifo_order", {24'h0, f_head}, 32'hA2 + 32'(i));
            f_pop = 1'b1;
            @(posedge clk); #1;
            f_pop = 1'b0;
        end
        check("fifo_empty", {31'h0, f_empty}, 32'h1);
        check("fifo_count0", {29'h0, f_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
